// File: rtl/serv_alu_seq.sv
// -----------------------------------------------------------------------------
// serv_alu_seq -- bit-serial ALU sequencer.
//
// Steps a 32-bit bit-serial ALU through one operation.
//   * Single-stage ops run one 32-cycle RUN pass.
//   * Two-stage ops (shift, slt, branch compare) first make a 32-cycle INIT pass,
//     then a RUN pass.
//   * Shifts also park in SHWAIT between the two passes. They stay there until
//     the shifter reports that its shift-amount countdown has finished.
//
// Ports
//   clk          in   clock, rising edge
//   i_rst        in   asynchronous active-high reset
//   i_req        in   operation request (transfer when i_req && o_ready)
//   i_two_stage  in   op needs an INIT pass (sampled at transfer)
//   i_shift      in   op is a shift (sampled at transfer)
//   i_sh_done    in   shifter finished its countdown (only looked at in SHWAIT)
//   o_ready      out  idle, can accept a request
//   o_ack        out  one-cycle completion pulse (first IDLE cycle after RUN)
//   o_en         out  ALU bit enable (INIT or RUN)
//   o_init       out  ALU init-pass indicator
//   o_cnt0       out  current bit is bit 0
//   o_cnt_done   out  current bit is bit 31
//   o_shamt_en   out  shift-amount register load enable
//   o_cnt[4:0]   out  current bit index
// -----------------------------------------------------------------------------
module serv_alu_seq (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_req,
    input  logic       i_two_stage,
    input  logic       i_shift,
    input  logic       i_sh_done,
    output logic       o_ready,
    output logic       o_ack,
    output logic       o_en,
    output logic       o_init,
    output logic       o_cnt0,
    output logic       o_cnt_done,
    output logic       o_shamt_en,
    output logic [4:0] o_cnt
);

    localparam logic [4:0] CNT_LAST  = 5'd31;
    localparam logic [4:0] SHAMT_LEN = 5'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_SHWAIT,
        S_RUN
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_next;
    logic       r_shift;
    logic       w_shift_next;
    logic       r_ack;
    logic       w_ack_next;
    logic       w_en;

    // State, bit counter, latched op type and ack pulse.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 5'd0;
            r_shift <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_shift <= w_shift_next;
            r_ack   <= w_ack_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_next = r_shift;
        w_ack_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_state_next = i_two_stage ? S_INIT : S_RUN;
                    w_cnt_next   = 5'd0;
                    w_shift_next = i_shift;
                end
            end
            S_INIT: begin
                // The 5-bit counter wraps 31 -> 0 naturally at the end of the pass.
                w_cnt_next = r_cnt + 5'd1;
                if (r_cnt == CNT_LAST) begin
                    w_state_next = r_shift ? S_SHWAIT : S_RUN;
                end
            end
            S_SHWAIT: begin
                w_cnt_next = 5'd0;
                if (i_sh_done) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_cnt_next = r_cnt + 5'd1;
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_IDLE;
                    w_ack_next   = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 5'd0;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    // Reset therefore reaches them immediately, without a clock edge.
    assign w_en       = (r_state == S_INIT) || (r_state == S_RUN);
    assign o_ready    = (r_state == S_IDLE);
    assign o_ack      = r_ack;
    assign o_en       = w_en;
    assign o_init     = (r_state == S_INIT);
    assign o_cnt0     = w_en && (r_cnt == 5'd0);
    assign o_cnt_done = w_en && (r_cnt == CNT_LAST);
    assign o_shamt_en = (r_state == S_INIT) && r_shift && (r_cnt < SHAMT_LEN);
    assign o_cnt      = r_cnt;

endmodule

// File: tb/tb_serv_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_serv_alu_seq -- directed self-checking bench for serv_alu_seq.
//
// The outputs are packed into one 12-bit word:
//   {ready, ack, en, init, cnt0, cnt_done, shamt_en, cnt[4:0]}
// Each cycle of an operation is compared against the word implied by the
// cycle-latency table.
// -----------------------------------------------------------------------------
module tb_serv_alu_seq;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_req;
    logic       i_two_stage;
    logic       i_shift;
    logic       i_sh_done;
    logic       o_ready;
    logic       o_ack;
    logic       o_en;
    logic       o_init;
    logic       o_cnt0;
    logic       o_cnt_done;
    logic       o_shamt_en;
    logic [4:0] o_cnt;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [11:0] IDLE_VEC = 12'h800;

    serv_alu_seq dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_two_stage (i_two_stage),
        .i_shift     (i_shift),
        .i_sh_done   (i_sh_done),
        .o_ready     (o_ready),
        .o_ack       (o_ack),
        .o_en        (o_en),
        .o_init      (o_init),
        .o_cnt0      (o_cnt0),
        .o_cnt_done  (o_cnt_done),
        .o_shamt_en  (o_shamt_en),
        .o_cnt       (o_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] out_vec();
        return {o_ready, o_ack, o_en, o_init, o_cnt0, o_cnt_done, o_shamt_en, o_cnt};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b exp=%b (rdy,ack,en,init,c0,cdone,shamt,cnt)", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The task is entered in the transfer cycle T and returns in the ack cycle.
    // The caller may start the next op in that same cycle.
    //   s_at    : cycle index (relative to T) at which i_sh_done is driven high in SHWAIT
    //   stray   : toggle op inputs and i_sh_done outside SHWAIT
    //   abort_k : if nonzero, assert reset asynchronously during cycle abort_k
    task automatic run_op(input string name, input bit ts, input bit sh,
                          input int s_at, input bit stray, input int abort_k);
        int          run_start;
        int          ack_k;
        logic [11:0] exp;
        bit          in_init;
        bit          in_wait;
        bit          in_run;
        logic [4:0]  c;
        run_start = ts ? (sh ? s_at + 1 : 33) : 1;
        ack_k     = run_start + 32;

        i_req       = 1'b1;
        i_two_stage = ts;
        i_shift     = sh;
        i_sh_done   = stray ? 1'b1 : 1'b0;
        check($sformatf("%s ready@T", name), {11'd0, o_ready}, 12'd1);
        tick();
        i_req = 1'b0;

        for (int k = 1; k <= ack_k; k++) begin
            in_init = ts && (k <= 32);
            in_wait = ts && sh && (k > 32) && (k < run_start);
            in_run  = !in_init && !in_wait && (k < ack_k);
            if (in_init)     c = 5'(k - 1);
            else if (in_run) c = 5'(k - run_start);
            else             c = 5'd0;

            if (in_wait) begin
                i_sh_done = (k == s_at);
            end else if (stray && k < ack_k) begin
                i_sh_done   = 1'($urandom_range(1, 0));
                i_two_stage = 1'($urandom_range(1, 0));
                i_shift     = 1'($urandom_range(1, 0));
            end else begin
                i_sh_done   = 1'b0;
                i_two_stage = 1'b0;
                i_shift     = 1'b0;
            end

            exp = {(k == ack_k), (k == ack_k), (in_init || in_run), in_init,
                   ((in_init || in_run) && c == 5'd0),
                   ((in_init || in_run) && c == 5'd31),
                   (in_init && sh && k <= 5), c};
            check($sformatf("%s T+%0d", name, k), out_vec(), exp);

            if (abort_k != 0 && k == abort_k) begin
                #2;
                i_rst = 1'b1;
                #1;
                check($sformatf("%s async reset", name), out_vec(), IDLE_VEC);
                return;
            end
            if (k < ack_k) tick();
        end
        i_sh_done = 1'b0;
    endtask

    initial begin
        i_rst       = 1'b1;
        i_req       = 1'b0;
        i_two_stage = 1'b0;
        i_shift     = 1'b0;
        i_sh_done   = 1'b0;
        tick();
        tick();
        check("reset values", out_vec(), IDLE_VEC);

        // Release reset, then idle with stray i_sh_done pulses: nothing may start.
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            i_sh_done = i[0];
            tick();
            check($sformatf("idle hold %0d", i), out_vec(), IDLE_VEC);
        end
        i_sh_done = 1'b0;

        run_op("single", 1'b0, 1'b0, 0, 1'b0, 0);
        tick();
        check("single ack one cycle", out_vec(), IDLE_VEC);

        run_op("cmp2", 1'b1, 1'b0, 0, 1'b0, 0);
        tick();
        check("cmp2 post", out_vec(), IDLE_VEC);

        run_op("shift40", 1'b1, 1'b1, 40, 1'b0, 0);
        tick();
        check("shift40 post", out_vec(), IDLE_VEC);

        run_op("shift33", 1'b1, 1'b1, 33, 1'b0, 0);
        tick();
        check("shift33 post", out_vec(), IDLE_VEC);

        run_op("shift1stage", 1'b0, 1'b1, 0, 1'b0, 0);
        tick();
        check("shift1stage post", out_vec(), IDLE_VEC);

        // Back-to-back: each op is started in the previous op's ack cycle.
        run_op("b2b_a", 1'b0, 1'b0, 0, 1'b0, 0);
        run_op("b2b_b", 1'b1, 1'b0, 0, 1'b1, 0);
        run_op("b2b_c", 1'b1, 1'b1, 45, 1'b1, 0);
        run_op("b2b_d", 1'b0, 1'b0, 0, 1'b1, 0);
        tick();
        check("b2b post", out_vec(), IDLE_VEC);

        // Abort in RUN at cnt=17 (cycle T+18).
        run_op("abort", 1'b0, 1'b0, 0, 1'b0, 18);
        tick();
        check("abort held", out_vec(), IDLE_VEC);
        i_rst = 1'b0;
        tick();
        check("abort no ack", out_vec(), IDLE_VEC);
        run_op("after abort", 1'b1, 1'b0, 0, 1'b0, 0);
        tick();
        check("after abort post", out_vec(), IDLE_VEC);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Safety net in case the simulation stalls.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
